// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer
// Multicycle sequencer in front of the one-hot-controlled ALU. Accepts one
// operation at a time over valid/ready, registers the operands, holds the
// one-hot ALU control for the required number of cycles, then captures the
// ALU's ZHI/ZLO outputs and reports completion for one cycle.
//
// Ports:
//   clock, clear            clock and synchronous active-high reset
//   req_valid / req_ready   request handshake
//   op, a_in, b_in          opcode (0..11 legal) and operands
//   alu_a, alu_b, alu_ctrl  registered operands and one-hot control to the ALU
//   alu_zhi, alu_zlo        ALU results
//   result_hi, result_lo    captured results, held until next capture/clear
//   hi_we, lo_we            HI/LO write strobes (mul/div only, in DONE)
//   done, err               completion pulse and its error qualifier
//   busy                    high whenever not IDLE
module alu_op_sequencer #(
    parameter int unsigned MULDIV_CYCLES = 4,
    parameter int unsigned CNT_W         = 4
) (
    input  logic        clock,
    input  logic        clear,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  op,
    input  logic [31:0] a_in,
    input  logic [31:0] b_in,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [11:0] alu_ctrl,
    input  logic [31:0] alu_zhi,
    input  logic [31:0] alu_zlo,
    output logic [31:0] result_lo,
    output logic [31:0] result_hi,
    output logic        hi_we,
    output logic        lo_we,
    output logic        done,
    output logic        err,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        DONE
    } state_t;

    localparam logic [CNT_W-1:0] MD_N  = CNT_W'(MULDIV_CYCLES);
    localparam logic [CNT_W-1:0] ONE_N = CNT_W'(1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       op_q;
    logic             op_muldiv;
    logic [CNT_W-1:0] exec_n;
    logic             acc_err;

    always_comb begin
        op_muldiv = (op_q == 4'd8) || (op_q == 4'd9);
        exec_n    = op_muldiv ? MD_N : ONE_N;
        // Evaluated on the live request; only used at the accept edge.
        acc_err   = (op >= 4'd12) || ((op == 4'd9) && (b_in == '0));
    end

    // Every output is a register set on the transition into the state it
    // belongs to, so nothing depends combinationally on req_valid or op.
    always_ff @(posedge clock) begin
        if (clear) begin
            state     <= IDLE;
            cnt       <= '0;
            op_q      <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_ctrl  <= '0;
            result_lo <= '0;
            result_hi <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
            hi_we     <= 1'b0;
            lo_we     <= 1'b0;
            busy      <= 1'b0;
            req_ready <= 1'b1;
        end else begin
            done  <= 1'b0;
            err   <= 1'b0;
            hi_we <= 1'b0;
            lo_we <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        alu_a     <= a_in;
                        alu_b     <= b_in;
                        op_q      <= op;
                        busy      <= 1'b1;
                        req_ready <= 1'b0;
                        if (acc_err) begin
                            // Rejected ops skip EXEC entirely; ALU never driven.
                            state     <= DONE;
                            result_lo <= '0;
                            result_hi <= '0;
                            done      <= 1'b1;
                            err       <= 1'b1;
                        end else begin
                            state    <= EXEC;
                            cnt      <= ONE_N;
                            alu_ctrl <= 12'd1 << op;
                        end
                    end
                end
                EXEC: begin
                    if (cnt == exec_n) begin
                        result_lo <= alu_zlo;
                        result_hi <= alu_zhi;
                        alu_ctrl  <= '0;
                        state     <= DONE;
                        done      <= 1'b1;
                        hi_we     <= op_muldiv;
                        lo_we     <= op_muldiv;
                    end else begin
                        cnt <= cnt + ONE_N;
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    cnt       <= '0;
                    busy      <= 1'b0;
                    req_ready <= 1'b1;
                end
                default: begin
                    state     <= IDLE;
                    cnt       <= '0;
                    alu_ctrl  <= '0;
                    busy      <= 1'b0;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Testbench for alu_op_sequencer: table-driven directed vectors, hand-written
// multi-cycle sequences, and randomized requests checked against an
// arithmetic reference model.
module tb_alu_op_sequencer;

    localparam int unsigned MC = 4;

    logic        clock = 1'b0;
    logic        clear;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  op;
    logic [31:0] a_in, b_in;
    logic [31:0] alu_a, alu_b;
    logic [11:0] alu_ctrl;
    logic [31:0] alu_zhi, alu_zlo;
    logic [31:0] result_lo, result_hi;
    logic        hi_we, lo_we, done, err, busy;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clock = ~clock;

    alu_op_sequencer #(
        .MULDIV_CYCLES(MC),
        .CNT_W        (4)
    ) dut (
        .clock    (clock),
        .clear    (clear),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .op       (op),
        .a_in     (a_in),
        .b_in     (b_in),
        .alu_a    (alu_a),
        .alu_b    (alu_b),
        .alu_ctrl (alu_ctrl),
        .alu_zhi  (alu_zhi),
        .alu_zlo  (alu_zlo),
        .result_lo(result_lo),
        .result_hi(result_hi),
        .hi_we    (hi_we),
        .lo_we    (lo_we),
        .done     (done),
        .err      (err),
        .busy     (busy)
    );

    // Reference arithmetic: {hi, lo} for each opcode.
    function automatic logic [63:0] ref_alu(input logic [3:0] o, input logic [31:0] a,
                                            input logic [31:0] b);
        int s;
        s = int'(b[4:0]);
        case (o)
            4'd0:    return {32'd0, a + b};
            4'd1:    return {32'd0, a - b};
            4'd2:    return {32'd0, a >> s};
            4'd3:    return {32'd0, a << s};
            4'd4:    return {32'd0, (a >> s) | (a << (32 - s))};
            4'd5:    return {32'd0, (a << s) | (a >> (32 - s))};
            4'd6:    return {32'd0, a & b};
            4'd7:    return {32'd0, a | b};
            4'd8:    return 64'(a) * 64'(b);
            4'd9:    return (b == 0) ? 64'd0 : {a % b, a / b};
            4'd10:   return {32'd0, -a};
            4'd11:   return {32'd0, ~a};
            default: return 64'd0;
        endcase
    endfunction

    // ALU model: drives a marker pattern whenever the control is not one-hot,
    // so a capture in the wrong cycle shows up as a wrong result.
    logic [63:0] alu_r;
    always_comb begin
        alu_r = {32'hDEAD_BEEF, 32'hDEAD_BEEF};
        for (int i = 0; i < 12; i++)
            if (alu_ctrl == (12'd1 << i)) alu_r = ref_alu(4'(i), alu_a, alu_b);
        alu_zhi = alu_r[63:32];
        alu_zlo = alu_r[31:0];
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One request from an idle sequencer, checked cycle by cycle.
    task automatic run_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_lo, input logic [31:0] exp_hi,
                          input logic exp_err);
        int  k, lat, ctrl_cycles, exp_lat, exp_ctrl;
        bit  seen, muldiv;
        muldiv   = (o == 4'd8) || (o == 4'd9);
        exp_lat  = exp_err ? 1 : (muldiv ? int'(MC) + 1 : 2);
        exp_ctrl = exp_err ? 0 : (muldiv ? int'(MC) : 1);
        k = 0;
        @(negedge clock);
        while (!req_ready && k < 50) begin
            @(negedge clock);
            k++;
        end
        chk("ready_before_req", 64'(req_ready), 64'd1);
        req_valid = 1'b1;
        op   = o;
        a_in = a;
        b_in = b;
        seen = 1'b0;
        lat  = 0;
        ctrl_cycles = 0;
        for (int c = 1; c <= 40 && !seen; c++) begin
            @(negedge clock);
            // Scramble the inputs: the sequencer must work from its latched copy.
            req_valid = 1'b0;
            op   = 4'($urandom);
            a_in = $urandom;
            b_in = $urandom;
            if (alu_ctrl != 12'd0) begin
                ctrl_cycles++;
                chk("alu_ctrl_onehot", 64'(alu_ctrl), 64'(12'd1 << o));
                chk("alu_a_stable", 64'(alu_a), 64'(a));
                chk("alu_b_stable", 64'(alu_b), 64'(b));
            end
            if (done) begin
                seen = 1'b1;
                lat  = c;
                chk("err", 64'(err), 64'(exp_err));
                chk("result_lo", 64'(result_lo), 64'(exp_lo));
                chk("result_hi", 64'(result_hi), 64'(exp_hi));
                chk("hi_we", 64'(hi_we), 64'(muldiv && !exp_err));
                chk("lo_we", 64'(lo_we), 64'(muldiv && !exp_err));
            end
        end
        if (!seen) begin
            n_chk++;
            n_fail++;
            $display("FAIL done_timeout: op %0d no done within 40 cycles", o);
        end else begin
            chk("latency", 64'(lat), 64'(exp_lat));
            chk("ctrl_cycles", 64'(ctrl_cycles), 64'(exp_ctrl));
            @(negedge clock);
            chk("done_one_cycle", 64'(done), 64'd0);
            chk("ready_after_done", 64'(req_ready), 64'd1);
        end
    endtask

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] lo;
        logic [31:0] hi;
        logic        e;
    } vec_t;

    vec_t tbl[17];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] r;
        logic [3:0]  ro;
        logic [31:0] ra, rb;
        logic        re;

        tbl[0]  = '{4'd0,  32'd5,          32'd7,          32'd12,          32'd0, 1'b0};
        tbl[1]  = '{4'd1,  32'd10,         32'd3,          32'd7,           32'd0, 1'b0};
        tbl[2]  = '{4'd2,  32'h8000_0000,  32'd4,          32'h0800_0000,   32'd0, 1'b0};
        tbl[3]  = '{4'd3,  32'd1,          32'd31,         32'h8000_0000,   32'd0, 1'b0};
        tbl[4]  = '{4'd4,  32'd1,          32'd1,          32'h8000_0000,   32'd0, 1'b0};
        tbl[5]  = '{4'd5,  32'h8000_0000,  32'd1,          32'd1,           32'd0, 1'b0};
        tbl[6]  = '{4'd6,  32'hF0F0,       32'hFF00,       32'hF000,        32'd0, 1'b0};
        tbl[7]  = '{4'd7,  32'hF0,         32'h0F,         32'hFF,          32'd0, 1'b0};
        tbl[8]  = '{4'd8,  32'h0001_0000,  32'h0001_0000,  32'd0,           32'd1, 1'b0};
        tbl[9]  = '{4'd8,  32'hFFFF_FFFF,  32'd2,          32'hFFFF_FFFE,   32'd1, 1'b0};
        tbl[10] = '{4'd9,  32'd17,         32'd5,          32'd3,           32'd2, 1'b0};
        tbl[11] = '{4'd10, 32'd1,          32'd0,          32'hFFFF_FFFF,   32'd0, 1'b0};
        tbl[12] = '{4'd11, 32'd0,          32'd0,          32'hFFFF_FFFF,   32'd0, 1'b0};
        tbl[13] = '{4'd9,  32'd10,         32'd0,          32'd0,           32'd0, 1'b1};
        tbl[14] = '{4'd13, 32'd1,          32'd2,          32'd0,           32'd0, 1'b1};
        tbl[15] = '{4'd12, 32'd3,          32'd4,          32'd0,           32'd0, 1'b1};
        tbl[16] = '{4'd15, 32'd5,          32'd6,          32'd0,           32'd0, 1'b1};

        clear = 1'b1;
        req_valid = 1'b0;
        op = '0;
        a_in = '0;
        b_in = '0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("rst_req_ready", 64'(req_ready), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_alu_ctrl", 64'(alu_ctrl), 64'd0);
        chk("rst_result_lo", 64'(result_lo), 64'd0);
        chk("rst_alu_a", 64'(alu_a), 64'd0);
        clear = 1'b0;

        for (int i = 0; i < 17; i++)
            run_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].lo, tbl[i].hi, tbl[i].e);

        // Clear for two cycles in the middle of a multiply.
        @(negedge clock);
        req_valid = 1'b1;
        op = 4'd8;
        a_in = 32'd3;
        b_in = 32'd4;
        @(negedge clock);
        req_valid = 1'b0;
        @(negedge clock);
        chk("mid_mul_ctrl", 64'(alu_ctrl), 64'h100);
        clear = 1'b1;
        repeat (2) @(negedge clock);
        clear = 1'b0;
        @(negedge clock);
        chk("clr_busy", 64'(busy), 64'd0);
        chk("clr_alu_ctrl", 64'(alu_ctrl), 64'd0);
        chk("clr_done", 64'(done), 64'd0);
        chk("clr_req_ready", 64'(req_ready), 64'd1);
        chk("clr_result_lo", 64'(result_lo), 64'd0);
        repeat (6) begin
            @(negedge clock);
            chk("clr_no_late_done", 64'(done), 64'd0);
        end

        // Illegal op followed by a held request accepted right after DONE.
        req_valid = 1'b1;
        op = 4'd13;
        a_in = 32'd9;
        b_in = 32'd9;
        @(negedge clock);
        chk("b2b_err_done", 64'(done), 64'd1);
        chk("b2b_err_err", 64'(err), 64'd1);
        op = 4'd11;
        a_in = 32'd0;
        b_in = 32'd0;
        @(negedge clock);
        chk("b2b_idle_ready", 64'(req_ready), 64'd1);
        chk("b2b_idle_no_done", 64'(done), 64'd0);
        @(negedge clock);
        req_valid = 1'b0;
        chk("b2b_exec_ctrl", 64'(alu_ctrl), 64'h800);
        @(negedge clock);
        chk("b2b_not_done", 64'(done), 64'd1);
        chk("b2b_not_err", 64'(err), 64'd0);
        chk("b2b_not_result", 64'(result_lo), 64'hFFFF_FFFF);

        // Request pulsed while busy must be dropped.
        @(negedge clock);
        req_valid = 1'b1;
        op = 4'd0;
        a_in = 32'd5;
        b_in = 32'd7;
        @(negedge clock);
        op = 4'd8;
        a_in = 32'd99;
        b_in = 32'd99;
        @(negedge clock);
        req_valid = 1'b0;
        chk("ign_done", 64'(done), 64'd1);
        chk("ign_result", 64'(result_lo), 64'd12);
        chk("ign_alu_a", 64'(alu_a), 64'd5);
        repeat (4) begin
            @(negedge clock);
            chk("ign_no_extra_done", 64'(done), 64'd0);
            chk("ign_idle_ctrl", 64'(alu_ctrl), 64'd0);
        end
        chk("ign_alu_b", 64'(alu_b), 64'd7);

        // Randomized requests against the arithmetic model.
        for (int n = 0; n < 60; n++) begin
            ro = 4'($urandom_range(0, 15));
            ra = $urandom;
            rb = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            re = (ro >= 4'd12) || (ro == 4'd9 && rb == 32'd0);
            r  = re ? 64'd0 : ref_alu(ro, ra, rb);
            run_op(ro, ra, rb, r[31:0], r[63:32], re);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
